// File: rtl/block_padding_cfg_seq.sv
// Store-side block-padding configuration sequencer: parses the ST loop-word stream,
// multiplies out legal/full point counts with a shift-add engine and publishes them.
module block_padding_cfg_seq #(
    parameter int IMM_WIDTH   = 16,
    parameter int LOOP_ITER_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_block_padding_v,
    input  logic [IMM_WIDTH-1:0]     diff_rows,
    input  logic                     upsample_required,
    input  logic                     cfg_loop_iter_st_v,
    input  logic                     cfg_loop_iter_st1_v,
    input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter_st,
    output logic [LOOP_ITER_W-1:0]   width_st,
    output logic [LOOP_ITER_W-1:0]   height_st,
    output logic [LOOP_ITER_W-1:0]   oc_st,
    output logic [2*LOOP_ITER_W-1:0] data_legal_points,
    output logic [2*LOOP_ITER_W-1:0] data_full_points,
    output logic [2*LOOP_ITER_W-1:0] addr_legal_points,
    output logic [2*LOOP_ITER_W-1:0] addr_full_points,
    output logic                     st1_exist,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_valid,
    output logic                     cfg_error
);

    localparam int PW   = 2 * LOOP_ITER_W;
    localparam int CW   = $clog2(LOOP_ITER_W + 1);
    localparam int CMPW = (IMM_WIDTH > LOOP_ITER_W) ? IMM_WIDTH : LOOP_ITER_W;
    localparam logic [CW-1:0] LAST_ITER = CW'(LOOP_ITER_W - 1);

    typedef enum logic [3:0] {
        S_HDR  = 4'd0,
        S_UPR  = 4'd1,
        S_UPL  = 4'd2,
        S_W    = 4'd3,
        S_H    = 4'd4,
        S_OC   = 4'd5,
        S_B    = 4'd6,
        S_MUL  = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic                   up_q, up_d;
    logic [IMM_WIDTH-1:0]   diff_q, diff_d;
    logic [LOOP_ITER_W-1:0] width_q, width_d;
    logic [LOOP_ITER_W-1:0] height_q, height_d;
    logic [LOOP_ITER_W-1:0] oc_q, oc_d;
    logic [PW-1:0]          dlp_q, dlp_d;
    logic [PW-1:0]          dfp_q, dfp_d;
    logic [PW-1:0]          alp_q, alp_d;
    logic [PW-1:0]          afp_q, afp_d;
    logic                   st1_q, st1_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          mcand_q, mcand_d;
    logic [LOOP_ITER_W-1:0] mpf_q, mpf_d;
    logic [LOOP_ITER_W-1:0] mpl_q, mpl_d;
    logic [PW-1:0]          accf_q, accf_d;
    logic [PW-1:0]          accl_q, accl_d;

    logic [CMPW-1:0]        h_ext_s;
    logic [CMPW-1:0]        d_ext_s;
    logic                   clamp_s;
    logic [LOOP_ITER_W-1:0] legal_rows_s;
    logic [PW-1:0]          accf_nx_s;
    logic [PW-1:0]          accl_nx_s;

    // Legal row count for the multiplier; rows at or below the blocked count clamp to zero.
    always_comb begin
        h_ext_s      = CMPW'(height_q);
        d_ext_s      = CMPW'(diff_q);
        clamp_s      = (d_ext_s >= h_ext_s);
        legal_rows_s = '0;
        if (clamp_s) begin
            legal_rows_s = '0;
        end else begin
            legal_rows_s = LOOP_ITER_W'(h_ext_s - d_ext_s);
        end
    end

    // One shift-add step for both products.
    always_comb begin
        accf_nx_s = accf_q;
        accl_nx_s = accl_q;
        if (mpf_q[0]) begin
            accf_nx_s = accf_q + mcand_q;
        end else begin
            accf_nx_s = accf_q;
        end
        if (mpl_q[0]) begin
            accl_nx_s = accl_q + mcand_q;
        end else begin
            accl_nx_s = accl_q;
        end
    end

    // Next-state and output-register computation.
    always_comb begin
        state_d  = state_q;
        up_d     = up_q;
        diff_d   = diff_q;
        width_d  = width_q;
        height_d = height_q;
        oc_d     = oc_q;
        dlp_d    = dlp_q;
        dfp_d    = dfp_q;
        alp_d    = alp_q;
        afp_d    = afp_q;
        st1_d    = st1_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mpf_d    = mpf_q;
        mpl_d    = mpl_q;
        accf_d   = accf_q;
        accl_d   = accl_q;

        // The branch-store mode tracks whichever stream spoke last; ST wins ties.
        if (cfg_loop_iter_st_v) begin
            st1_d = 1'b0;
        end else if (cfg_loop_iter_st1_v) begin
            st1_d = 1'b1;
        end else begin
            st1_d = st1_q;
        end

        if (cfg_block_padding_v) begin
            diff_d   = diff_rows;
            state_d  = S_HDR;
            up_d     = 1'b0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b0;
            width_d  = '0;
            height_d = '0;
            oc_d     = '0;
            dlp_d    = '0;
            dfp_d    = '0;
            alp_d    = '0;
            afp_d    = '0;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (cfg_loop_iter_st_v) begin
                        up_d    = upsample_required;
                        busy_d  = 1'b1;
                        state_d = upsample_required ? S_UPR : S_W;
                    end else begin
                        state_d = S_HDR;
                    end
                end
                S_UPR: begin
                    if (cfg_loop_iter_st_v) begin
                        state_d = S_UPL;
                    end else begin
                        state_d = S_UPR;
                    end
                end
                S_UPL: begin
                    if (cfg_loop_iter_st_v) begin
                        state_d = S_W;
                    end else begin
                        state_d = S_UPL;
                    end
                end
                S_W: begin
                    if (cfg_loop_iter_st_v) begin
                        width_d = cfg_loop_iter_st + LOOP_ITER_W'(1);
                        state_d = S_H;
                    end else begin
                        state_d = S_W;
                    end
                end
                S_H: begin
                    if (cfg_loop_iter_st_v) begin
                        height_d = cfg_loop_iter_st + LOOP_ITER_W'(1);
                        state_d  = S_OC;
                    end else begin
                        state_d = S_H;
                    end
                end
                S_OC: begin
                    if (cfg_loop_iter_st_v) begin
                        oc_d    = cfg_loop_iter_st;
                        state_d = S_B;
                    end else begin
                        state_d = S_OC;
                    end
                end
                S_B: begin
                    if (cfg_loop_iter_st_v) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        mcand_d = PW'(width_q);
                        mpf_d   = height_q;
                        mpl_d   = legal_rows_s;
                        accf_d  = '0;
                        accl_d  = '0;
                        if (clamp_s) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        state_d = S_B;
                    end
                end
                S_MUL: begin
                    if (cfg_loop_iter_st_v) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    accf_d  = accf_nx_s;
                    accl_d  = accl_nx_s;
                    mcand_d = mcand_q << 1;
                    mpf_d   = mpf_q >> 1;
                    mpl_d   = mpl_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    // The final step's sums go straight into the published registers.
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_DONE;
                        dfp_d   = accf_nx_s << 1;
                        dlp_d   = accl_nx_s << 1;
                        afp_d   = up_q ? (accf_nx_s << 3) : (accf_nx_s << 1);
                        alp_d   = up_q ? (accl_nx_s << 3) : (accl_nx_s << 1);
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_MUL;
                    end
                end
                S_DONE: begin
                    state_d = S_HDR;
                end
                default: begin
                    state_d = S_HDR;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_HDR;
            up_q     <= 1'b0;
            diff_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            oc_q     <= '0;
            dlp_q    <= '0;
            dfp_q    <= '0;
            alp_q    <= '0;
            afp_q    <= '0;
            st1_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mpf_q    <= '0;
            mpl_q    <= '0;
            accf_q   <= '0;
            accl_q   <= '0;
        end else begin
            state_q  <= state_d;
            up_q     <= up_d;
            diff_q   <= diff_d;
            width_q  <= width_d;
            height_q <= height_d;
            oc_q     <= oc_d;
            dlp_q    <= dlp_d;
            dfp_q    <= dfp_d;
            alp_q    <= alp_d;
            afp_q    <= afp_d;
            st1_q    <= st1_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mpf_q    <= mpf_d;
            mpl_q    <= mpl_d;
            accf_q   <= accf_d;
            accl_q   <= accl_d;
        end
    end

    assign width_st          = width_q;
    assign height_st         = height_q;
    assign oc_st             = oc_q;
    assign data_legal_points = dlp_q;
    assign data_full_points  = dfp_q;
    assign addr_legal_points = alp_q;
    assign addr_full_points  = afp_q;
    assign st1_exist         = st1_q;
    assign cfg_busy          = busy_q;
    assign cfg_done          = done_q;
    assign cfg_valid         = valid_q;
    assign cfg_error         = err_q;

endmodule

// File: tb/tb_block_padding_cfg_seq.sv
// Scoreboard bench for block_padding_cfg_seq: expected configurations are queued as
// word sequences are driven and compared when cfg_done fires.
module tb_block_padding_cfg_seq;

    logic        clk;
    logic        reset;
    logic        cfg_block_padding_v;
    logic [15:0] diff_rows;
    logic        upsample_required;
    logic        cfg_loop_iter_st_v;
    logic        cfg_loop_iter_st1_v;
    logic [15:0] cfg_loop_iter_st;
    logic [15:0] width_st, height_st, oc_st;
    logic [31:0] data_legal_points, data_full_points, addr_legal_points, addr_full_points;
    logic        st1_exist, cfg_busy, cfg_done, cfg_valid, cfg_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] w, h, oc;
        logic [31:0] df, dl, af, al;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    block_padding_cfg_seq #(.IMM_WIDTH(16), .LOOP_ITER_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_block_padding_v(cfg_block_padding_v),
        .diff_rows          (diff_rows),
        .upsample_required  (upsample_required),
        .cfg_loop_iter_st_v (cfg_loop_iter_st_v),
        .cfg_loop_iter_st1_v(cfg_loop_iter_st1_v),
        .cfg_loop_iter_st   (cfg_loop_iter_st),
        .width_st           (width_st),
        .height_st          (height_st),
        .oc_st              (oc_st),
        .data_legal_points  (data_legal_points),
        .data_full_points   (data_full_points),
        .addr_legal_points  (addr_legal_points),
        .addr_full_points   (addr_full_points),
        .st1_exist          (st1_exist),
        .cfg_busy           (cfg_busy),
        .cfg_done           (cfg_done),
        .cfg_valid          (cfg_valid),
        .cfg_error          (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [175:0] dut_vec();
        return {width_st, height_st, oc_st, data_full_points, data_legal_points,
                addr_full_points, addr_legal_points};
    endfunction

    function automatic logic [175:0] exp_vec(input exp_t e);
        return {e.w, e.h, e.oc, e.df, e.dl, e.af, e.al};
    endfunction

    task automatic push_exp(input logic [15:0] wword, input logic [15:0] hword,
                            input logic [15:0] ocword, input logic [15:0] diff,
                            input bit up, input bit extra_err);
        exp_t e;
        logic [31:0] full, legal;
        e.w   = wword + 16'd1;
        e.h   = hword + 16'd1;
        e.oc  = ocword;
        full  = 32'(e.w) * 32'(e.h);
        legal = (diff >= e.h) ? 32'd0 : 32'(e.w) * 32'(e.h - diff);
        e.df  = full << 1;
        e.dl  = legal << 1;
        e.af  = up ? (full << 3) : (full << 1);
        e.al  = up ? (legal << 3) : (legal << 1);
        e.err = (diff >= e.h) || extra_err;
        sb_q.push_back(e);
    endtask

    task automatic drive_word(input logic [15:0] w);
        cfg_loop_iter_st_v = 1'b1;
        cfg_loop_iter_st   = w;
        @(posedge clk); #1;
        cfg_loop_iter_st_v = 1'b0;
        cfg_loop_iter_st   = 16'h0000;
    endtask

    task automatic pulse_bp(input logic [15:0] d);
        cfg_block_padding_v = 1'b1;
        diff_rows           = d;
        @(posedge clk); #1;
        cfg_block_padding_v = 1'b0;
    endtask

    task automatic run_seq(input bit up, input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] oc);
        upsample_required = up;
        drive_word(16'h00A5);
        upsample_required = 1'b0;
        if (up) begin
            drive_word(16'h1234);
            drive_word(16'h4321);
        end
        drive_word(w);
        drive_word(h);
        drive_word(oc);
        drive_word(16'h0000);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({dut_vec(), st1_exist, cfg_busy, cfg_done, cfg_valid, cfg_error} !== 181'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0",
                     {dut_vec(), st1_exist, cfg_busy, cfg_done, cfg_valid, cfg_error});
        end
    endtask

    task automatic test_no_upsample();
        int cyc;
        exp_t e;
        pulse_bp(16'd2);
        push_exp(16'd15, 16'd7, 16'd3, 16'd2, 1'b0, 1'b0);
        run_seq(1'b0, 16'd15, 16'd7, 16'd3);
        checks++;
        if (cfg_busy !== 1'b1) begin
            errors++;
            $display("FAIL nu_busy got=%b want=1", cfg_busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL nu_latency got=%0d want=17", cyc);
        end
        e = sb_q.pop_front();
        checks++;
        if (dut_vec() !== exp_vec(e)) begin
            errors++;
            $display("FAIL nu_points got=%h want=%h", dut_vec(), exp_vec(e));
        end
        checks++;
        if ({cfg_valid, cfg_busy, cfg_error} !== {1'b1, 1'b0, e.err}) begin
            errors++;
            $display("FAIL nu_flags got=%b want=%b", {cfg_valid, cfg_busy, cfg_error},
                     {1'b1, 1'b0, e.err});
        end
        @(negedge clk);
        checks++;
        if ({cfg_done, cfg_valid} !== 2'b01) begin
            errors++;
            $display("FAIL nu_done_pulse got=%b want=01", {cfg_done, cfg_valid});
        end
    endtask

    task automatic test_upsample();
        int cyc;
        exp_t e;
        pulse_bp(16'd2);
        push_exp(16'd15, 16'd7, 16'd3, 16'd2, 1'b1, 1'b0);
        run_seq(1'b1, 16'd15, 16'd7, 16'd3);
        wait_done(cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL up_latency got=%0d want=17", cyc);
        end
        e = sb_q.pop_front();
        checks++;
        if (dut_vec() !== exp_vec(e) || cfg_error !== e.err) begin
            errors++;
            $display("FAIL up_points got=%h/%b want=%h/%b", dut_vec(), cfg_error, exp_vec(e), e.err);
        end
    endtask

    task automatic test_clamp();
        int cyc;
        exp_t e;
        pulse_bp(16'd10);
        push_exp(16'd15, 16'd7, 16'd3, 16'd10, 1'b0, 1'b0);
        run_seq(1'b0, 16'd15, 16'd7, 16'd3);
        wait_done(cyc);
        checks++;
        if (cyc == 0) begin
            errors++;
            $display("FAIL clamp_timeout got=none want=cfg_done");
        end
        e = sb_q.pop_front();
        checks++;
        if (dut_vec() !== exp_vec(e) || cfg_error !== 1'b1) begin
            errors++;
            $display("FAIL clamp_points got=%h/%b want=%h/1", dut_vec(), cfg_error, exp_vec(e));
        end
        pulse_bp(16'd0);
        checks++;
        if ({cfg_error, cfg_valid} !== 2'b00) begin
            errors++;
            $display("FAIL clamp_clear got=%b want=00", {cfg_error, cfg_valid});
        end
    endtask

    task automatic test_diff_zero();
        int cyc;
        exp_t e;
        pulse_bp(16'd0);
        push_exp(16'd4, 16'd9, 16'd1, 16'd0, 1'b0, 1'b0);
        run_seq(1'b0, 16'd4, 16'd9, 16'd1);
        wait_done(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc == 0 || dut_vec() !== exp_vec(e) || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL diff0_points got=%h/%b cyc=%0d want=%h/0", dut_vec(), cfg_error, cyc, exp_vec(e));
        end
    endtask

    task automatic test_abort();
        int cyc;
        int dones;
        exp_t e;
        pulse_bp(16'd2);
        run_seq(1'b0, 16'd15, 16'd7, 16'd3);
        repeat (3) @(posedge clk);
        #1;
        pulse_bp(16'd2);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_done got=%0d want=0", dones);
        end
        checks++;
        if ({dut_vec(), cfg_valid, cfg_busy} !== 178'd0) begin
            errors++;
            $display("FAIL abort_clear got=%h want=0", {dut_vec(), cfg_valid, cfg_busy});
        end
        push_exp(16'd15, 16'd7, 16'd3, 16'd2, 1'b0, 1'b0);
        run_seq(1'b0, 16'd15, 16'd7, 16'd3);
        wait_done(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc != 17 || dut_vec() !== exp_vec(e)) begin
            errors++;
            $display("FAIL abort_fresh got=%h cyc=%0d want=%h cyc=17", dut_vec(), cyc, exp_vec(e));
        end
    endtask

    task automatic test_overrun_mode();
        int cyc;
        exp_t e;
        pulse_bp(16'd2);
        push_exp(16'd15, 16'd7, 16'd3, 16'd2, 1'b0, 1'b1);
        run_seq(1'b0, 16'd15, 16'd7, 16'd3);
        repeat (3) @(posedge clk);
        #1;
        drive_word(16'h0055);
        wait_done(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc == 0 || dut_vec() !== exp_vec(e) || cfg_error !== e.err) begin
            errors++;
            $display("FAIL overrun got=%h/%b cyc=%0d want=%h/%b", dut_vec(), cfg_error, cyc, exp_vec(e), e.err);
        end
        cfg_loop_iter_st1_v = 1'b1;
        @(posedge clk); #1;
        cfg_loop_iter_st1_v = 1'b0;
        @(negedge clk);
        checks++;
        if (st1_exist !== 1'b1) begin
            errors++;
            $display("FAIL st1_alone got=%b want=1", st1_exist);
        end
        pulse_bp(16'd1);
        checks++;
        if (st1_exist !== 1'b1) begin
            errors++;
            $display("FAIL st1_bp_keep got=%b want=1", st1_exist);
        end
        cfg_loop_iter_st1_v = 1'b1;
        drive_word(16'h00A5);
        cfg_loop_iter_st1_v = 1'b0;
        checks++;
        if (st1_exist !== 1'b0) begin
            errors++;
            $display("FAIL st_st1_tie got=%b want=0", st1_exist);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        exp_t e;
        pulse_bp(16'd2);
        drive_word(16'h00A5);
        drive_word(16'd15);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({dut_vec(), st1_exist, cfg_busy, cfg_done, cfg_valid, cfg_error} !== 181'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=0",
                     {dut_vec(), st1_exist, cfg_busy, cfg_done, cfg_valid, cfg_error});
        end
        pulse_bp(16'd2);
        push_exp(16'd15, 16'd7, 16'd3, 16'd2, 1'b0, 1'b0);
        run_seq(1'b0, 16'd15, 16'd7, 16'd3);
        wait_done(cyc);
        e = sb_q.pop_front();
        checks++;
        if (cyc != 17 || dut_vec() !== exp_vec(e)) begin
            errors++;
            $display("FAIL reset_mid_seq got=%h cyc=%0d want=%h cyc=17", dut_vec(), cyc, exp_vec(e));
        end
    endtask

    initial begin
        reset               = 1'b1;
        cfg_block_padding_v = 1'b0;
        diff_rows           = 16'd0;
        upsample_required   = 1'b0;
        cfg_loop_iter_st_v  = 1'b0;
        cfg_loop_iter_st1_v = 1'b0;
        cfg_loop_iter_st    = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_no_upsample();
        test_upsample();
        test_clamp();
        test_diff_zero();
        test_abort();
        test_overrun_mode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
